// File: rtl/otf_converter.sv
// otf_converter: serial MSD-first on-the-fly conversion of a radix-2 signed-digit word to two's complement.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; din_p/din_n/din_msd_n are latched on acceptance
//   din_p, din_n          positive/negative digit components, bit i weighs +/-2^i
//   din_msd_n             top digit at position no_of_digits, value -din_msd_n
//   out_valid/out_ready   output handshake; dout held stable while out_valid is high
//   dout                  two's-complement result, no_of_digits+2 bits
//   out_zero, out_sign    dout==0 and dout sign bit (only with OTF_CONVERTER_STATUS_EN)
module otf_converter #(
   parameter int no_of_digits = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [no_of_digits-1:0] din_p,
   input  logic [no_of_digits-1:0] din_n,
   input  logic                    din_msd_n,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [no_of_digits+1:0] dout
`ifdef OTF_CONVERTER_STATUS_EN
   ,
   output logic                    out_zero,
   output logic                    out_sign
`endif
);
   localparam int W  = no_of_digits + 2;
   localparam int CW = $clog2(no_of_digits + 1);
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   state_t                state_q;
   logic [no_of_digits:0] p_q, n_q;
   logic [W-1:0]          q_q, qm_q, q_d, qm_d;
   logic [CW-1:0]         cnt_q;
   logic                  dp, dn;
   // The top digit lives at index no_of_digits with only a negative component.
   always_comb begin
      dp   = p_q[cnt_q];
      dn   = n_q[cnt_q];
      q_d  = (dp & ~dn) ? {q_q[W-2:0], 1'b1}  : (dn & ~dp) ? {qm_q[W-2:0], 1'b1} : {q_q[W-2:0], 1'b0};
      qm_d = (dp & ~dn) ? {q_q[W-2:0], 1'b0}  : (dn & ~dp) ? {qm_q[W-2:0], 1'b0} : {qm_q[W-2:0], 1'b1};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         dout      <= '0;
         q_q       <= '0;
         qm_q      <= '1;
         cnt_q     <= '0;
         p_q       <= '0;
         n_q       <= '0;
`ifdef OTF_CONVERTER_STATUS_EN
         out_zero  <= 1'b0;
         out_sign  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               p_q      <= {1'b0, din_p};
               n_q      <= {din_msd_n, din_n};
               q_q      <= '0;
               qm_q     <= '1;
               cnt_q    <= CW'(no_of_digits);
               in_ready <= 1'b0;
               state_q  <= CONV;
            end
            CONV: begin
               q_q   <= q_d;
               qm_q  <= qm_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q <= DONE;
`ifdef OTF_CONVERTER_STATUS_EN
                  out_zero <= (q_d == '0);
                  out_sign <= q_d[W-1];
`endif
               end
            end
            DONE: if (!out_valid) begin
               out_valid <= 1'b1;
               dout      <= q_q;
            end else if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_otf_converter.sv
// tb_otf_converter: directed-vector bench for otf_converter (no_of_digits=8).
module tb_otf_converter;
   localparam int N = 8;
   localparam int W = N + 2;
   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic         din_msd_n = 1'b0;
   logic [N-1:0] din_p = '0;
   logic [N-1:0] din_n = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] dout;
   logic [W-1:0] inv_exp;
   int           checks = 0;
   int           errors = 0;
`ifdef OTF_CONVERTER_STATUS_EN
   logic         out_zero, out_sign;
`endif
   always #5 clk = ~clk;
   otf_converter #(.no_of_digits(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .din_p(din_p), .din_n(din_n), .din_msd_n(din_msd_n),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
`ifdef OTF_CONVERTER_STATUS_EN
      , .out_zero(out_zero), .out_sign(out_sign)
`endif
   );
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   // QM must trail Q by one at all times outside reset.
   always_comb inv_exp = dut.q_q - W'(1);
   always @(negedge clk) if (rst_n) check("inv", 32'(dut.qm_q), 32'(inv_exp));
   task automatic accept(input logic [N-1:0] p, input logic [N-1:0] n, input logic msd);
      int c;
      @(negedge clk);
      din_p = p; din_n = n; din_msd_n = msd; in_valid = 1'b1;
      c = 0;
      while (!in_ready && c < 30) begin
         @(negedge clk);
         c++;
      end
      if (!in_ready) check("in_ready timeout", 0, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask
   task automatic wait_valid(output int c);
      c = 0;
      while (!out_valid && c < 30) begin
         @(posedge clk);
         #1;
         c++;
      end
   endtask
   task automatic word(input string tag, input logic [N-1:0] p, input logic [N-1:0] n,
                       input logic msd, input logic [W-1:0] exp);
      int c;
      accept(p, n, msd);
      wait_valid(c);
      check({tag, " lat"}, c, 10);
      check({tag, " dout"}, 32'(dout), 32'(exp));
`ifdef OTF_CONVERTER_STATUS_EN
      check({tag, " zero"}, 32'(out_zero), 32'(exp == '0));
      check({tag, " sign"}, 32'(out_sign), 32'(exp[W-1]));
`endif
      @(posedge clk);
      #1 check({tag, " hs"}, 32'(out_valid), 0);
      check({tag, " idle"}, 32'(in_ready), 1);
   endtask
   initial begin
      int c;
      logic seen;
      #2 rst_n = 1'b0;
      #10;
      check("rst in_ready", 32'(in_ready), 1);
      check("rst out_valid", 32'(out_valid), 0);
      check("rst dout", 32'(dout), 0);
      @(negedge clk) rst_n = 1'b1;
      word("zero", 8'h00, 8'h00, 1'b0, 10'h000);
      word("max", 8'hFF, 8'h00, 1'b0, 10'h0FF);
      word("min", 8'h00, 8'hFF, 1'b1, 10'h201);
      word("m129", 8'h80, 8'h01, 1'b1, 10'h37F);
      word("pn11", 8'hFF, 8'hFF, 1'b0, 10'h000);
      word("mix", 8'h0F, 8'hF0, 1'b0, 10'h31F);
      // backpressure: result held while a second word is offered
      out_ready = 1'b0;
      accept(8'h80, 8'h01, 1'b1);
      wait_valid(c);
      check("bp lat", c, 10);
      din_p = 8'h55; din_n = 8'h00; din_msd_n = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp valid", 32'(out_valid), 1);
         check("bp dout", 32'(dout), 32'h37F);
         check("bp in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      #1 check("bp release valid", 32'(out_valid), 0);
      check("bp release idle", 32'(in_ready), 1);
      word("after bp", 8'h01, 8'h00, 1'b0, 10'h001);
      // reset in the middle of conversion
      accept(8'hFF, 8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid rst in_ready", 32'(in_ready), 1);
      check("mid rst out_valid", 32'(out_valid), 0);
      check("mid rst dout", 32'(dout), 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1 seen |= out_valid;
      end
      check("mid rst no valid", 32'(seen), 0);
      check("mid rst ready", 32'(in_ready), 1);
      word("post rst", 8'h00, 8'h02, 1'b0, 10'h3FE);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
